// File: rtl/regfile_2r1w_clr_if.sv
// Bus bundle for the 2R/1W register file: clear handshake, two read ports, one write port.
interface regfile_2r1w_clr_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) ();
    logic              clr_req;
    logic              ready;
    logic              rd0_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic [DATA_W-1:0] rd0_data;
    logic              rd0_valid;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_drop;

    modport master (
        output clr_req, rd0_en, rd0_addr, rd1_en, rd1_addr,
        output wr_en, wr_addr, wr_data,
        input  ready, rd0_data, rd0_valid, rd1_data, rd1_valid, wr_drop
    );

    modport slave (
        input  clr_req, rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  wr_en, wr_addr, wr_data,
        output ready, rd0_data, rd0_valid, rd1_data, rd1_valid, wr_drop
    );
endinterface

// File: rtl/regfile_2r1w_clr.sv
// Parametrised 2-read/1-write register file with a one-entry-per-cycle clear sweep,
// optional write-to-read bypass and optional hardwired-zero entry 0.
module regfile_2r1w_clr #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    regfile_2r1w_clr_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   clr_idx, clr_idx_nx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_commit;
    logic              wr_store;
    logic              drop_nx;
    logic [DATA_W-1:0] rd0_q, rd1_q;
    logic              rd0_v, rd1_v, drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        unique case (state)
            CLEAR: begin
                clr_idx_nx = clr_idx + 1'b1;
                if (clr_idx == (ADDR_W+1)'(DEPTH-1))
                    state_nx = READY;
            end
            READY: begin
                if (bus.clr_req) begin
                    state_nx   = CLEAR;
                    clr_idx_nx = '0;
                end
            end
            default: ;
        endcase
    end

    // A clear request in the same cycle pre-empts the write
    assign wr_commit = (state == READY) && bus.wr_en && !bus.clr_req;
    assign wr_store  = wr_commit && !(ZERO_REG && bus.wr_addr == '0);
    assign drop_nx   = bus.wr_en && ((state != READY) || bus.clr_req);

    function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a);
        if (ZERO_REG && a == '0)
            return '0;
        if (BYPASS && wr_commit && a == bus.wr_addr)
            return bus.wr_data;
        return mem[a];
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR)
                mem[clr_idx[ADDR_W-1:0]] <= '0;
            else if (wr_store)
                mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd0_q  <= '0;
            rd1_q  <= '0;
            rd0_v  <= 1'b0;
            rd1_v  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            rd0_v  <= (state == READY) && bus.rd0_en;
            rd1_v  <= (state == READY) && bus.rd1_en;
            drop_q <= drop_nx;
            if (state == READY && bus.rd0_en)
                rd0_q <= rd_mux(bus.rd0_addr);
            if (state == READY && bus.rd1_en)
                rd1_q <= rd_mux(bus.rd1_addr);
        end
    end

    assign bus.ready     = (state == READY);
    assign bus.rd0_data  = rd0_q;
    assign bus.rd0_valid = rd0_v;
    assign bus.rd1_data  = rd1_q;
    assign bus.rd1_valid = rd1_v;
    assign bus.wr_drop   = drop_q;
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Bench for regfile_2r1w_clr: two instances (bypass/no-zero and no-bypass/zero-reg)
// driven by the same stimulus and checked against a behavioural model every cycle.
module tb_regfile_2r1w_clr;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_req, rd0_en, rd1_en, wr_en;
    logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
    logic [DW-1:0] wr_data;

    regfile_2r1w_clr_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
    regfile_2r1w_clr_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

    assign ifa.clr_req = clr_req;
    assign ifa.rd0_en = rd0_en;
    assign ifa.rd0_addr = rd0_addr;
    assign ifa.rd1_en = rd1_en;
    assign ifa.rd1_addr = rd1_addr;
    assign ifa.wr_en = wr_en;
    assign ifa.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data;
    assign ifb.clr_req = clr_req;
    assign ifb.rd0_en = rd0_en;
    assign ifb.rd0_addr = rd0_addr;
    assign ifb.rd1_en = rd1_en;
    assign ifb.rd1_addr = rd1_addr;
    assign ifb.wr_en = wr_en;
    assign ifb.wr_addr = wr_addr;
    assign ifb.wr_data = wr_data;

    regfile_2r1w_clr #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1), .ZERO_REG(1'b0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    regfile_2r1w_clr #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0), .ZERO_REG(1'b1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    // Model: instance 0 = bypass on, instance 1 = zero-reg on
    logic [DW-1:0] m [2][DEPTH];
    int            left [2];
    logic [DW-1:0] e_rdd [2][2];
    logic          e_rdv [2][2];
    logic          e_drop [2];

    int nvec = 0;
    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit bp = (d == 0);
            bit zr = (d == 1);
            bit wrote;
            logic [AW-1:0] ra [2];
            logic          re [2];
            ra[0] = rd0_addr; ra[1] = rd1_addr;
            re[0] = rd0_en;   re[1] = rd1_en;
            if (!rst_n) begin
                left[d] = DEPTH;
                e_drop[d] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    e_rdv[d][p] = 1'b0;
                    e_rdd[d][p] = '0;
                end
            end else if (left[d] > 0) begin
                m[d][DEPTH - left[d]] = '0;
                left[d]--;
                e_drop[d] = wr_en;
                for (int p = 0; p < 2; p++) e_rdv[d][p] = 1'b0;
            end else begin
                wrote = wr_en && !clr_req;
                for (int p = 0; p < 2; p++) begin
                    e_rdv[d][p] = re[p];
                    if (re[p]) begin
                        if (zr && ra[p] == 0) e_rdd[d][p] = '0;
                        else if (bp && wrote && ra[p] == wr_addr) e_rdd[d][p] = wr_data;
                        else e_rdd[d][p] = m[d][ra[p]];
                    end
                end
                e_drop[d] = wr_en && clr_req;
                if (wrote && !(zr && wr_addr == 0)) m[d][wr_addr] = wr_data;
                if (clr_req) left[d] = DEPTH;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        nvec++;
        #1;
        chk($sformatf("a.ready@%0d", nvec), 32'(ifa.ready), 32'(left[0] == 0));
        chk($sformatf("a.rd0_valid@%0d", nvec), 32'(ifa.rd0_valid), 32'(e_rdv[0][0]));
        chk($sformatf("a.rd1_valid@%0d", nvec), 32'(ifa.rd1_valid), 32'(e_rdv[0][1]));
        chk($sformatf("a.rd0_data@%0d", nvec), 32'(ifa.rd0_data), 32'(e_rdd[0][0]));
        chk($sformatf("a.rd1_data@%0d", nvec), 32'(ifa.rd1_data), 32'(e_rdd[0][1]));
        chk($sformatf("a.wr_drop@%0d", nvec), 32'(ifa.wr_drop), 32'(e_drop[0]));
        chk($sformatf("b.ready@%0d", nvec), 32'(ifb.ready), 32'(left[1] == 0));
        chk($sformatf("b.rd0_valid@%0d", nvec), 32'(ifb.rd0_valid), 32'(e_rdv[1][0]));
        chk($sformatf("b.rd1_valid@%0d", nvec), 32'(ifb.rd1_valid), 32'(e_rdv[1][1]));
        chk($sformatf("b.rd0_data@%0d", nvec), 32'(ifb.rd0_data), 32'(e_rdd[1][0]));
        chk($sformatf("b.rd1_data@%0d", nvec), 32'(ifb.rd1_data), 32'(e_rdd[1][1]));
        chk($sformatf("b.wr_drop@%0d", nvec), 32'(ifb.wr_drop), 32'(e_drop[1]));
    endtask

    task automatic idle();
        clr_req = 0; rd0_en = 0; rd1_en = 0; wr_en = 0;
        rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
        idle();
        wr_en = 1; wr_addr = a; wr_data = v;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int d = 0; d < 2; d++) left[d] = DEPTH;

        // T1: reset then sweep; ready low for 32 cycles
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) step();
        for (int i = 0; i < 4; i++) begin
            idle();
            rd0_en = 1; rd0_addr = AW'($urandom);
            rd1_en = 1; rd1_addr = AW'($urandom);
            step();
        end

        // T2: write then read
        wr(7, 16'hBEEF); step();
        idle(); rd0_en = 1; rd0_addr = 7; rd1_en = 1; rd1_addr = 8; step();
        idle(); step();

        // T3: same-cycle write and read on both ports
        wr(3, 16'h5555); step();
        wr(3, 16'h1234); rd0_en = 1; rd0_addr = 3; rd1_en = 1; rd1_addr = 3; step();
        idle(); rd0_en = 1; rd0_addr = 3; step();

        // T6: write to entry 0 with bypass read
        wr(0, 16'hFFFF); rd0_en = 1; rd0_addr = 0; step();
        idle(); rd0_en = 1; rd0_addr = 0; rd1_en = 1; rd1_addr = 0; step();

        // Random traffic, addresses biased low so bypass hits are common
        for (int i = 0; i < 300; i++) begin
            bit narrow = ($urandom_range(0, 1) == 1);
            clr_req  = ($urandom_range(0, 63) == 0);
            rd0_en   = $urandom_range(0, 1) == 1;
            rd1_en   = $urandom_range(0, 1) == 1;
            wr_en    = $urandom_range(0, 2) != 0;
            rd0_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
            rd1_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr_addr  = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr_data  = DW'($urandom);
            step();
        end
        idle();
        for (int i = 0; i < 34; i++) step();

        // T4: fill, clear, write during sweep, read back
        for (int a = 0; a < DEPTH; a++) begin
            wr(AW'(a), DW'(a + 1)); step();
        end
        idle(); clr_req = 1; step();
        for (int i = 0; i < 32; i++) begin
            idle();
            wr_en = (i % 3 == 0); wr_addr = AW'(i); wr_data = 16'hA5A5;
            clr_req = (i == 5);
            rd0_en = 1; rd0_addr = AW'(i);
            step();
        end
        for (int a = 0; a < DEPTH; a += 2) begin
            idle();
            rd0_en = 1; rd0_addr = AW'(a);
            rd1_en = 1; rd1_addr = AW'(a + 1);
            step();
        end

        // T5: clear and write together, then reset mid-sweep
        wr(9, 16'h7777); step();
        wr(9, 16'h8888); clr_req = 1; step();
        idle();
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0; wr_en = 1; wr_addr = 4; wr_data = 16'h4444; step();
        rst_n = 1'b1; idle();
        for (int i = 0; i < 33; i++) step();
        idle(); rd0_en = 1; rd0_addr = 9; rd1_en = 1; rd1_addr = 4; step();
        idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
